// File: rtl/lut_selftest_seq.sv
// Exhaustive self-test sequencer for a 4-input dual-rail logic cell.
// Walks all 16 input vectors, samples the cell after a settle interval, and checks value and rail code.
module lut_selftest_seq #(
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] GOLDEN = 16'h6996
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       e_in,
  input  logic       e_chk,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_err,
  output logic       code_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned VEC_W = 4;
  localparam int unsigned ERR_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic [CNT_W-1:0] cnt;

  // Evaluation of the sampled cell for the current vector
  logic             rail_bad_c;
  logic             fail_c;
  logic [ERR_W-1:0] err_next_c;
  logic             code_next_c;

  assign rail_bad_c  = (e_in == e_chk);
  assign fail_c      = (e_in != GOLDEN[vec]) | rail_bad_c;
  assign err_next_c  = err_count + ERR_W'(fail_c);
  assign code_next_c = code_err | rail_bad_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      vec       <= '0;
      cnt       <= '0;
      {a, b, c, d} <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      first_err <= '0;
      code_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            vec          <= '0;
            cnt          <= CNT_W'(SETTLE - 1);
            err_count    <= '0;
            first_err    <= '0;
            code_err     <= 1'b0;
            pass         <= 1'b0;
            {a, b, c, d} <= '0;
            busy         <= 1'b1;
            state        <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (abort) begin
            busy         <= 1'b0;
            {a, b, c, d} <= '0;
            state        <= S_IDLE;
          end else if (cnt == '0) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_CHECK: begin
          if (abort) begin
            // Sample of an aborted check is dropped
            busy         <= 1'b0;
            {a, b, c, d} <= '0;
            state        <= S_IDLE;
          end else begin
            if (fail_c) begin
              err_count <= err_next_c;
              if (err_count == '0) first_err <= vec;
            end
            code_err <= code_next_c;
            if (vec == VEC_W'(15)) begin
              pass         <= (err_next_c == '0) & ~code_next_c;
              busy         <= 1'b0;
              done         <= 1'b1;
              {a, b, c, d} <= '0;
              state        <= S_DONE;
            end else begin
              vec          <= vec + VEC_W'(1);
              {a, b, c, d} <= vec + VEC_W'(1);
              cnt          <= CNT_W'(SETTLE - 1);
              state        <= S_WAIT;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_selftest_seq.sv
// Self-checking bench for lut_selftest_seq: table-driven cell model plus per-run reference results.
module tb_lut_selftest_seq;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned HOLD   = SETTLE + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       e_in;
  logic       e_chk;
  logic       a, b, c, d;
  logic       busy, done, pass, code_err;
  logic [4:0] err_count;
  logic [3:0] first_err;

  logic [15:0] e_tab = 16'h0;
  logic [15:0] chk_tab = 16'hFFFF;

  int errors = 0;
  int checks = 0;

  lut_selftest_seq #(.SETTLE(SETTLE), .GOLDEN(16'h6996)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .e_in(e_in), .e_chk(e_chk),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err(first_err), .code_err(code_err)
  );

  always #5 clk = ~clk;

  // Cell under test: lookup of whatever behaviour the current test installs
  always_comb begin
    e_in  = e_tab[{a, b, c, d}];
    e_chk = chk_tab[{a, b, c, d}];
  end

  // Expected function: 4-input parity, derived independently of the DUT's GOLDEN parameter
  function automatic logic [15:0] xor_tab();
    logic [15:0] t;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] vv;
      vv = 4'(v);
      t[v] = ^vv;
    end
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full run with result comparison against a vector-by-vector reference
  task automatic run_and_check(input string name, input logic [15:0] et, input logic [15:0] ct);
    logic [15:0] gt;
    int exp_err;
    int exp_first;
    logic exp_code;
    logic exp_pass;
    gt = xor_tab();
    exp_err = 0; exp_first = 0; exp_code = 1'b0;
    for (int v = 0; v < 16; v++) begin
      logic bad_rail;
      bad_rail = (et[v] == ct[v]);
      if (bad_rail) exp_code = 1'b1;
      if ((et[v] != gt[v]) || bad_rail) begin
        if (exp_err == 0) exp_first = v;
        exp_err++;
      end
    end
    exp_pass = (exp_err == 0) && !exp_code;

    e_tab = et; chk_tab = ct;
    start = 1'b1;
    tick();
    start = 1'b0;

    checks++;
    if (err_count !== 5'd0 || first_err !== 4'd0 || code_err !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL %s clear_at_start: got err=%0d first=%0d code=%0b pass=%0b required 0 0 0 0",
               name, err_count, first_err, code_err, pass);
    end

    for (int t = 0; t < 16 * int'(HOLD); t++) begin
      logic [3:0] exp_vec;
      exp_vec = 4'(t / int'(HOLD));
      checks++;
      if ({a, b, c, d} !== exp_vec || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s seq t=%0d: got vec=%0h busy=%0b done=%0b required vec=%0h busy=1 done=0",
                 name, t, {a, b, c, d}, busy, done, exp_vec);
      end
      start = ($urandom_range(0, 3) == 0);
      tick();
      start = 1'b0;
    end

    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {a, b, c, d} !== 4'd0) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%0b busy=%0b vec=%0h required 1 0 0",
               name, done, busy, {a, b, c, d});
    end
    checks++;
    if (err_count !== 5'(exp_err) || first_err !== 4'(exp_first) ||
        code_err !== exp_code || pass !== exp_pass) begin
      errors++;
      $display("FAIL %s results: got err=%0d first=%0d code=%0b pass=%0b required %0d %0d %0b %0b",
               name, err_count, first_err, code_err, pass, exp_err, exp_first, exp_code, exp_pass);
    end

    // start while in DONE must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== exp_pass || err_count !== 5'(exp_err)) begin
      errors++;
      $display("FAIL %s after_done: got done=%0b busy=%0b pass=%0b err=%0d required 0 0 %0b %0d",
               name, done, busy, pass, err_count, exp_pass, exp_err);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== exp_pass) begin
      errors++;
      $display("FAIL %s hold_idle: got busy=%0b done=%0b pass=%0b required 0 0 %0b",
               name, busy, done, pass, exp_pass);
    end
  endtask

  task automatic test_reset();
    logic [15:0] gt;
    gt = xor_tab();
    rst = 1'b1;
    #1;
    checks++;
    if ({a, b, c, d, busy, done, pass, code_err} !== 8'd0 || err_count !== 5'd0 || first_err !== 4'd0) begin
      errors++;
      $display("FAIL reset_initial: got outs=%0h err=%0d first=%0d required all 0",
               {a, b, c, d, busy, done, pass, code_err}, err_count, first_err);
    end
    tick();
    rst = 1'b0;
    tick();

    // Mid-run reset with a faulty cell so results are nonzero
    e_tab = 16'h0; chk_tab = ~gt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 20; t++) tick();
    checks++;
    if (busy !== 1'b1 || err_count !== 5'd3) begin
      errors++;
      $display("FAIL reset_premise: got busy=%0b err=%0d required 1 3", busy, err_count);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({a, b, c, d, busy, done, pass, code_err} !== 8'd0 || err_count !== 5'd0 || first_err !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: got outs=%0h err=%0d first=%0d required all 0",
               {a, b, c, d, busy, done, pass, code_err}, err_count, first_err);
    end
    tick();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) tick();
    checks++;
    if (busy !== 1'b0 || {a, b, c, d} !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%0b vec=%0h done=%0b required 0 0 0", busy, {a, b, c, d}, done);
    end
  endtask

  task automatic test_good();
    logic [15:0] gt;
    gt = xor_tab();
    run_and_check("good", gt, ~gt);
  endtask

  task automatic test_stuck0();
    logic [15:0] gt;
    gt = xor_tab();
    run_and_check("stuck0", 16'h0000, ~gt);
  endtask

  task automatic test_code_1011();
    logic [15:0] gt;
    gt = xor_tab();
    run_and_check("code_1011", gt, ~gt ^ 16'h0800);
  endtask

  task automatic test_random();
    logic [15:0] gt;
    logic [15:0] em;
    logic [15:0] cm;
    gt = xor_tab();
    for (int i = 0; i < 4; i++) begin
      em = 16'($urandom & $urandom & $urandom);
      cm = 16'($urandom & $urandom & $urandom);
      run_and_check("random", gt ^ em, ~(gt ^ em) ^ cm);
    end
  endtask

  task automatic test_abort();
    logic [15:0] gt;
    gt = xor_tab();
    // abort and start together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || {a, b, c, d} !== 4'd0) begin
      errors++;
      $display("FAIL abort_start_idle: got busy=%0b vec=%0h required 0 0", busy, {a, b, c, d});
    end

    e_tab = 16'h0; chk_tab = ~gt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 5 * int'(HOLD); t++) begin
      start = (t == 3 * int'(HOLD));
      tick();
      start = 1'b0;
    end
    checks++;
    if ({a, b, c, d} !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_premise: got vec=%0h busy=%0b required 5 1", {a, b, c, d}, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || {a, b, c, d} !== 4'd0) begin
      errors++;
      $display("FAIL abort_stop: got busy=%0b vec=%0h required 0 0", busy, {a, b, c, d});
    end
    begin
      int seen;
      seen = 0;
      for (int t = 0; t < 60; t++) begin
        if (done !== 1'b0 || busy !== 1'b0) seen++;
        tick();
      end
      checks++;
      if (seen != 0) begin
        errors++;
        $display("FAIL abort_quiet: got %0d active cycles required 0", seen);
      end
    end
    checks++;
    if (err_count !== 5'd3 || first_err !== 4'd1 || code_err !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL abort_partial: got err=%0d first=%0d code=%0b pass=%0b required 3 1 1 0",
               err_count, first_err, code_err, pass);
    end
    run_and_check("after_abort", gt, ~gt);
  endtask

  task automatic test_back_to_back();
    logic [15:0] gt;
    gt = xor_tab();
    run_and_check("b2b_faulty", gt ^ 16'h0120, ~(gt ^ 16'h0120));
    run_and_check("b2b_good", gt, ~gt);
  endtask

  initial begin
    test_reset();
    test_good();
    test_stuck0();
    test_code_1011();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lut_selftest_seq.md
Name: lut_selftest_seq

Overview:
- Sequencer that exhaustively exercises one 4-input self-checking logic cell (inputs a,b,c,d; dual-rail output pair e/e_chk).
- Steps through all 16 input vectors, waits a settle interval per vector, then checks two things on each vector:
  - the data output against a golden truth table;
  - the output pair for dual-rail code violations.
- Reports an error count, the first failing vector and a pass flag.
- Sits between the test/control logic and the cell under test; it is the cell's only input driver during a run.

Parameters:
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..15.
- GOLDEN, 16'h6996, expected e for vector index {a,b,c,d}, where a is the MSB (default = 4-input XOR).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  cancel a run in progress.
- e_in  input  1  data output of the cell under test.
- e_chk  input  1  checker rail of the cell; a healthy cell gives e_chk = ~e_in.
- a  output  1  vector bit 3, registered.
- b  output  1  vector bit 2, registered.
- c  output  1  vector bit 1, registered.
- d  output  1  vector bit 0, registered.
- busy  output  1  high in WAIT and CHECK.
- done  output  1  one-cycle pulse at end of a completed run.
- pass  output  1  run result; valid from done until the next start.
- err_count  output  5  number of failing vectors, 0..16.
- first_err  output  4  index of the first failing vector.
- code_err  output  1  sticky flag: at least one dual-rail violation this run.

Behaviour:
- Reset:
  - Asynchronous on rst=1, no clock required.
  - a,b,c,d,busy,done,pass,code_err = 0; err_count = 0; first_err = 0; state = IDLE.
  - Reset mid-run discards all progress.
- States: IDLE, WAIT, CHECK, DONE. All outputs are registered.
- IDLE:
  - On an edge with start=1 (edge E0): vec <= 0, cnt <= SETTLE-1, err_count <= 0, first_err <= 0, code_err <= 0, pass <= 0.
  - Then go to WAIT.
- WAIT:
  - {a,b,c,d} = vec.
  - If cnt==0, go to CHECK; else cnt <= cnt-1.
  - WAIT lasts exactly SETTLE cycles.
- CHECK (one cycle, during which the cell is sampled):
  - fail = (e_in != GOLDEN[vec]) | (e_in == e_chk).
  - If fail: err_count <= err_count+1.
  - If fail and err_count==0: first_err <= vec.
  - If e_in==e_chk: code_err <= 1.
  - If vec==15, go to DONE; else vec <= vec+1, cnt <= SETTLE-1, go to WAIT.
- Timing:
  - Each vector is held SETTLE+1 cycles.
  - Vector k is applied from edge E0 + k*(SETTLE+1).
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - pass = (err_count==0) & ~code_err, with the CHECK update for vector 15 included.
  - {a,b,c,d} = 0.
  - Next edge goes to IDLE; done drops there.
  - Total time: done is high during the cycle after edge E0 + 16*(SETTLE+1).
- Results: err_count, first_err, code_err and pass hold their values in IDLE until the next accepted start.
- start outside IDLE: ignored, including while in DONE.
- abort in WAIT or CHECK:
  - Next edge goes to IDLE; busy=0 and {a,b,c,d}=0.
  - No done pulse; pass stays 0.
  - err_count, first_err and code_err keep their partial values.
  - The sample in an aborted CHECK cycle is discarded.
- abort and start together in IDLE: abort wins; no run starts.
- err_count does not wrap: maximum is 16, which fits in 5 bits. first_err = 0 with err_count = 0 means "none".

Test Plan:
- Reset: assert rst mid-stream with outputs nonzero -> all outputs 0 immediately, before the next clock edge; state IDLE.
- Good cell model (e_in = ^{a,b,c,d}, e_chk = ~e_in), SETTLE=2, 1-cycle start at E0:
  - busy=1 after E0; each vector 0..15 held 3 cycles in order.
  - done pulses once, in the cycle after E0+48.
  - pass=1, err_count=0, code_err=0, first_err=0.
- e_in stuck-at-0, e_chk = ~GOLDEN[vec]:
  - 8 failing vectors: 1,2,4,7,8,11,13,14.
  - err_count=8, first_err=4'b0001, code_err=1, pass=0.
- Correct e_in but e_chk = e_in only on vector 4'b1011 -> err_count=1, first_err=4'b1011, code_err=1, pass=0.
- start pulse during vector 3, then abort during vector 5 -> run not restarted; busy=0 and {a,b,c,d}=0 one cycle after abort; no done pulse; a new start then runs the full 16 vectors.
- Two back-to-back runs (first faulty, second good) -> second run clears err_count, first_err and code_err at its start and ends with pass=1.
